// File: rtl/lmdpl_nor_eval.sv
// LMDPL NOR evaluation stage: precharge / evaluate / hold sequencing around a
// table lookup, with rail and table integrity checks on every accepted input.
module lmdpl_nor_eval #(
  parameter int PRE_CYCLES = 2,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       t,
  input  logic             a_t,
  input  logic             a_f,
  input  logic             b_t,
  input  logic             b_f,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             q_t,
  output logic             q_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {S_PRE, S_IDLE, S_HOLD} state_t;

  localparam logic [3:0] PRE_RLD = 4'(PRE_CYCLES - 1);

  state_t           r_state, w_nxt;
  logic [3:0]       r_cnt;
  logic             r_q_t, r_q_f, r_err;
  logic [ERR_W-1:0] r_err_cnt;

  logic       w_acc, w_ok, w_rel;
  logic [1:0] w_j;

  assign w_acc = in_valid && (r_state == S_IDLE);
  assign w_rel = out_ready && (r_state == S_HOLD);
  assign w_ok  = (a_t ^ a_f) & (b_t ^ b_f) & (t[7:4] == ~t[3:0]);
  assign w_j   = {~b_t, ~a_t};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_PRE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_PRE:   if (r_cnt == 4'd0) w_nxt = S_IDLE;
      S_IDLE:  if (w_acc) w_nxt = w_ok ? S_HOLD : S_PRE;
      S_HOLD:  if (out_ready) w_nxt = S_PRE;
      default: w_nxt = S_PRE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_HOLD);
  end

  // Counter reloads whenever a window (evaluation or reject) closes.
  always_ff @(posedge clk) begin
    if (rst)                                 r_cnt <= PRE_RLD;
    else if (w_nxt == S_PRE && r_state != S_PRE) r_cnt <= PRE_RLD;
    else if (r_state == S_PRE && r_cnt != 4'd0)  r_cnt <= r_cnt - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_t <= 1'b0;
      r_q_f <= 1'b0;
    end else if (w_acc) begin
      // Rejected inputs never reach the rails.
      r_q_t <= w_ok & t[{1'b0, w_j}];
      r_q_f <= w_ok & t[{1'b1, w_j}];
    end else if (w_rel) begin
      r_q_t <= 1'b0;
      r_q_f <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_acc & ~w_ok;
      if (w_acc && !w_ok && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign q_t     = r_q_t;
  assign q_f     = r_q_f;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_lmdpl_nor_eval.sv
// Transaction-level bench for lmdpl_nor_eval: tables built from mask triples,
// expected results from the masked NOR definition, protocol timing checked per cycle.
module tb_lmdpl_nor_eval;
  localparam int PRE = 2;
  localparam int EW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    t;
  logic          a_t, a_f, b_t, b_f;
  logic          in_valid, in_ready;
  logic          q_t, q_f, out_valid, out_ready;
  logic          err;
  logic [EW-1:0] err_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  lmdpl_nor_eval #(.PRE_CYCLES(PRE), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .t(t), .a_t(a_t), .a_f(a_f), .b_t(b_t), .b_f(b_f),
    .in_valid(in_valid), .in_ready(in_ready), .q_t(q_t), .q_f(q_f),
    .out_valid(out_valid), .out_ready(out_ready), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Masked NOR: result = NOR(a ^ m0, b ^ m1) ^ mo.
  function automatic logic nor_m(input logic a, input logic b,
                                 input logic m0, input logic m1, input logic mo);
    return ~((a ^ m0) | (b ^ m1)) ^ mo;
  endfunction

  // True-rail entry j answers operands a = ~j[0], b = ~j[1]; false rail is the complement.
  function automatic logic [7:0] gen_tbl(input logic m0, input logic m1, input logic mo);
    logic [3:0] lo;
    for (int j = 0; j < 4; j++) lo[j] = nor_m(~j[0], ~j[1], m0, m1, mo);
    return {~lo, lo};
  endfunction

  task automatic scramble_inputs();
    t   = 8'($urandom);
    a_t = 1'($urandom); a_f = 1'($urandom);
    b_t = 1'($urandom); b_f = 1'($urandom);
  endtask

  // Checks the precharge window after the closing edge, ending in IDLE.
  task automatic wait_pre(input string tag);
    chk({tag, "_pre0_rdy"}, in_ready, 0);
    chk({tag, "_pre0_q"}, {q_t, q_f, out_valid}, 0);
    for (int i = 1; i < PRE; i++) begin
      in_valid = 1'($urandom);
      scramble_inputs();
      tick();
      chk({tag, "_pre_rdy"}, in_ready, 0);
      chk({tag, "_pre_q"}, {q_t, q_f, out_valid, err}, 0);
    end
    in_valid = 1'b0;
    tick();
    chk({tag, "_idle_rdy"}, in_ready, 1);
    chk({tag, "_idle_q"}, {q_t, q_f, out_valid}, 0);
  endtask

  task automatic do_txn(input string tag, input logic m0, input logic m1, input logic mo,
                        input logic am, input logic bm, input logic [1:0] rail_bad,
                        input logic [7:0] t_xor, input int hold);
    logic ok, eq;
    chk({tag, "_rdy"}, in_ready, 1);
    t   = gen_tbl(m0, m1, mo) ^ t_xor;
    a_t = am; a_f = ~am ^ rail_bad[0];
    b_t = bm; b_f = ~bm ^ rail_bad[1];
    in_valid  = 1'b1;
    out_ready = 1'($urandom);
    ok = (rail_bad == 2'b00) && (t_xor == 8'h00);
    eq = nor_m(am, bm, m0, m1, mo);
    tick();
    in_valid = 1'b0;
    scramble_inputs();
    if (ok) begin
      chk({tag, "_ov"}, out_valid, 1);
      chk({tag, "_q"}, {q_t, q_f}, {eq, ~eq});
      chk({tag, "_err"}, err, 0);
      for (int i = 0; i < hold; i++) begin
        out_ready = 1'b0;
        in_valid  = 1'($urandom);
        tick();
        chk({tag, "_hold"}, {out_valid, q_t, q_f, in_ready}, {1'b1, eq, ~eq, 1'b0});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      wait_pre(tag);
    end else begin
      exp_cnt = (exp_cnt == (1 << EW) - 1) ? exp_cnt : exp_cnt + 1;
      chk({tag, "_rej"}, {out_valid, q_t, q_f, err}, 4'b0001);
      chk({tag, "_ecnt"}, err_cnt, exp_cnt);
      tick();
      chk({tag, "_errpulse"}, err, 0);
      for (int i = 2; i < PRE; i++) tick();
      in_valid = 1'b0;
      tick();
      chk({tag, "_idle_rdy"}, in_ready, 1);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    t = 8'h00; a_t = 0; a_f = 0; b_t = 0; b_f = 0;
    tick(); tick();
    chk("rst_outs", {in_ready, out_valid, q_t, q_f, err}, 0);
    chk("rst_ecnt", err_cnt, 0);

    // Hold a valid request across release of reset; acceptance happens in cycle 3.
    t = 8'h1e; a_t = 1; a_f = 0; b_t = 1; b_f = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    rst = 1'b0;
    tick();
    chk("boot_c1_rdy", in_ready, 0);
    tick();
    chk("boot_c2_rdy", in_ready, 1);
    chk("boot_c2_ov", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("boot_acc_ov", out_valid, 1);
    chk("boot_acc_q", {q_t, q_f}, 2'b01);
    tick();
    wait_pre("boot");

    // Directed: 1e with out_ready immediately, e1 held for 5 cycles.
    do_txn("d1e", 1, 1, 1, 1, 1, 2'b00, 8'h00, 0);
    do_txn("de1", 1, 1, 0, 0, 0, 2'b00, 8'h00, 5);

    // Full sweep: every mask triple (8 tables) by every operand pair.
    for (int m = 0; m < 8; m++)
      for (int o = 0; o < 4; o++)
        do_txn("sweep", m[0], m[1], m[2], o[0], o[1], 2'b00, 8'h00, $urandom_range(0, 2));

    // Directed rejects: rail collision and a corrupted table (1e -> 1f).
    do_txn("rej_rail", 1, 1, 1, 1, 1, 2'b01, 8'h00, 0);
    do_txn("rej_tbl", 1, 1, 1, 1, 1, 2'b00, 8'h01, 0);

    // Random mix of good and bad inputs.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] rb;
      logic [7:0] tx;
      rb = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tx = ($urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      do_txn("rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             rb, tx, $urandom_range(0, 3));
    end

    // Drive the error counter into saturation.
    for (int n = 0; n < 16; n++)
      do_txn("sat", 0, 0, 0, 1'($urandom), 1'($urandom), 2'b10, 8'h00, 0);
    chk("sat_final", err_cnt, 4'hf);

    // Reset during HOLD with out_ready high wins over the release handshake.
    do_txn("pre_rst", 0, 0, 0, 0, 1, 2'b00, 8'h00, 0);
    t = gen_tbl(0, 0, 1); a_t = 0; a_f = 1; b_t = 0; b_f = 1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst_hold_ov", out_valid, 1);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    chk("rst_hold_outs", {out_valid, q_t, q_f, err}, 0);
    chk("rst_hold_ecnt", err_cnt, 0);
    wait_pre("rst_hold");
    do_txn("post_rst", 1, 0, 1, 1, 0, 2'b00, 8'h00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lmdpl_nor_eval.md
Name: lmdpl_nor_eval

Overview:
- Sequential LMDPL NOR evaluation stage. It consumes the 8-bit LUT selector word produced by the NOR table generator, together with masked dual-rail operands.
- It produces a masked dual-rail NOR result under an explicit precharge/evaluate discipline, using a valid/ready handshake on both sides.
- Sits downstream of the table generator in the masked AES datapath. It enforces precharge-to-zero between evaluations and flags rail or table violations.

Parameters:
- PRE_CYCLES, 2, number of precharge cycles after each completed or aborted evaluation; legal range 1..15.
- ERR_W, 4, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- t  input  8  LUT selectors from table generator; t[3:0] true-rail table, t[7:4] false-rail table.
- a_t  input  1  operand A masked value, true rail.
- a_f  input  1  operand A masked value, false rail.
- b_t  input  1  operand B masked value, true rail.
- b_f  input  1  operand B masked value, false rail.
- in_valid  input  1  operands and t are presented.
- in_ready  output  1  block accepts operands this cycle.
- q_t  output  1  masked NOR result, true rail.
- q_f  output  1  masked NOR result, false rail.
- out_valid  output  1  q_t/q_f hold a valid evaluated pair.
- out_ready  input  1  consumer takes the result.
- err  output  1  one-cycle pulse on rejected input.
- err_cnt  output  ERR_W  saturating count of rejected inputs.

Behaviour:
- Reset:
  - state=PRE, pre counter=PRE_CYCLES-1.
  - in_ready=0, out_valid=0, q_t=0, q_f=0, err=0, err_cnt=0.
- States and transitions:
  - PRE: q_t=q_f=0, in_ready=0. Counter decrements each cycle. When the counter is 0, next state is IDLE.
  - IDLE: in_ready=1. An accept (in_valid & in_ready) in cycle N moves the block to HOLD at N+1 if the checks pass, otherwise to PRE.
  - HOLD: out_valid=1, q_t/q_f stable. When out_ready=1, on that edge q_t=q_f=0, out_valid=0, state=PRE, counter=PRE_CYCLES-1.
- Checks at accept:
  - Rail check: a_t^a_f=1 and b_t^b_f=1.
  - Table check: t[7:4]==~t[3:0].
- Evaluation at accept, registered on the accept edge:
  - Index j = {~bm, ~am}, where am=a_t and bm=b_t.
  - q_t <= t[j], q_f <= t[j+4].
  - Latency: accept in cycle N gives out_valid and result at cycle N+1.
- Reject (either check fails):
  - q_t/q_f stay 0.
  - err=1 at N+1 for exactly one cycle.
  - err_cnt increments, saturating at all-ones.
  - State becomes PRE with counter reloaded.
- Invariants:
  - q_t and q_f are never both 1.
  - Outputs are 0 in PRE and IDLE.
  - At most one evaluation per precharge window.
  - in_valid outside IDLE is ignored. Operands are not buffered.
- Simultaneous events: out_ready in the same cycle that out_valid rises is a legal handshake, so HOLD lasts a minimum of one cycle.
- rst asserted in any state (including HOLD with out_ready=1) overrides everything: reset values apply on the next edge and any result in flight is discarded.

Test Plan:
- Reset, then hold in_valid=1 → in_ready stays 0 for 2 cycles (PRE), rises in cycle 3, and the first accept is in cycle 3.
- t=8'h1e, a_t=1,a_f=0, b_t=1,b_f=0, out_ready=1 → next cycle q_t=0, q_f=1, out_valid=1 for one cycle. Then q pair returns to 0,0 and in_ready=0 for 2 cycles.
- t=8'he1, a_t=0,a_f=1, b_t=0,b_f=1 → q_t=0, q_f=1. Hold out_ready=0 for 5 cycles → outputs stable for 5 cycles and in_ready=0 throughout.
- Sweep all 8 tables (1e,2d,4b,87,e1,d2,b4,78) × 4 rail combinations against a reference model computing NOR(am^m0, bm^m1)^mo → q_t matches the model and q_f=~q_t in every case.
- a_t=1,a_f=1 (or t=8'h1f) → no out_valid, err=1 for one cycle, err_cnt=1. After 16 such rejects with ERR_W=4, err_cnt=4'hf.
- rst asserted in HOLD with out_ready=1 → next cycle q_t=q_f=0, out_valid=0, err_cnt=0, state PRE.
